// File: rtl/traceback_walker.sv
// Traceback walker: steps back from an end cell through the five-matrix affine-gap
// traceback memory and streams M/I/D ops downstream. Optional run-length merging: TB_RLE_EN.
module traceback_walker #(
    parameter int ROW_W = 8,
    parameter int COL_W = 8,
    parameter int LEN_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ROW_W-1:0] start_row,
    input  logic [COL_W-1:0] start_col,
    output logic             busy,
    output logic             done,
    output logic [ROW_W-1:0] end_row,
    output logic [COL_W-1:0] end_col,
    output logic             mem_rd_en,
    output logic [ROW_W-1:0] mem_row,
    output logic [COL_W-1:0] mem_col,
    input  logic [4:0]       mem_rdata,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [1:0]       op_code,
    output logic [LEN_W-1:0] op_len
);

    typedef enum logic [2:0] {
        S_M = 3'd0, S_I = 3'd1, S_D = 3'd2, S_STOP = 3'd3, S_IT = 3'd4, S_DT = 3'd5
    } tb_state_t;

    typedef enum logic [2:0] {IDLE, READ, WAIT, EVAL, EMIT, FINISH} fsm_t;

    localparam logic [1:0] OP_M = 2'd0;
    localparam logic [1:0] OP_I = 2'd1;
    localparam logic [1:0] OP_D = 2'd2;

    fsm_t             fsm, fsm_nx;
    logic [ROW_W-1:0] row_q;
    logic [COL_W-1:0] col_q;
    tb_state_t        pre_q;
    logic [4:0]       case_q;

    function automatic tb_state_t next_tb(input logic [4:0] c, input tb_state_t pre);
        tb_state_t s;
        s = S_STOP;
        if (c == 5'd0) begin
            s = S_STOP;
        end else if (c[4]) begin
            case (pre)
                S_M:     s = S_M;
                S_I:     s = c[3] ? S_I  : S_M;
                S_D:     s = c[2] ? S_D  : S_M;
                S_IT:    s = c[1] ? S_IT : S_M;
                S_DT:    s = c[0] ? S_DT : S_M;
                default: s = S_STOP;
            endcase
        end else begin
            case (pre)
                S_M: begin
                    case (c[3:2])
                        2'b00:   s = S_I;
                        2'b01:   s = S_D;
                        2'b10:   s = S_IT;
                        default: s = S_DT;
                    endcase
                end
                S_I, S_D, S_IT, S_DT: s = pre;
                default:              s = S_STOP;
            endcase
        end
        return s;
    endfunction

    tb_state_t        s_next;
    logic             is_stop, jump, term_mv, at_edge;
    logic [1:0]       mv_op;
    logic [ROW_W-1:0] mv_row;
    logic [COL_W-1:0] mv_col;

    // The op follows the state being entered, so a gap state that closes back into M
    // on this cell emits a diagonal move.
    always_comb begin
        s_next  = next_tb(case_q, pre_q);
        is_stop = (s_next == S_STOP);
        jump    = (pre_q == S_M) && !case_q[4] && !is_stop;
        case (s_next)
            S_M:       mv_op = OP_M;
            S_I, S_IT: mv_op = OP_I;
            default:   mv_op = OP_D;
        endcase
        mv_row  = (mv_op != OP_D) ? row_q - 1'b1 : row_q;
        mv_col  = (mv_op != OP_I) ? col_q - 1'b1 : col_q;
        term_mv = (mv_row == '0) || (mv_col == '0);
        at_edge = (row_q == '0) || (col_q == '0);
    end

`ifdef TB_RLE_EN
    logic             have_run, stopping;
    logic [1:0]       run_code;
    logic [LEN_W-1:0] run_len, new_len, op_len_q;
    logic             emit_now;

    always_comb begin
        new_len  = (have_run && mv_op == run_code) ? run_len + 1'b1 : LEN_W'(1);
        emit_now = (have_run && mv_op != run_code) || (new_len == '1) || term_mv;
    end
    assign op_len = op_len_q;
`else
    assign op_len = LEN_W'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_nx;
    end

    always_comb begin
        fsm_nx = fsm;
        case (fsm)
            IDLE: if (start) fsm_nx = (start_row == '0 || start_col == '0) ? FINISH : READ;
            READ: fsm_nx = WAIT;
            WAIT: fsm_nx = EVAL;
`ifdef TB_RLE_EN
            EVAL: begin
                if (is_stop)       fsm_nx = have_run ? EMIT : FINISH;
                else if (jump)     fsm_nx = READ;
                else if (emit_now) fsm_nx = EMIT;
                else               fsm_nx = READ;
            end
            EMIT: if (op_ready) fsm_nx = (at_edge || stopping) ? (have_run ? EMIT : FINISH) : READ;
`else
            EVAL: begin
                if (is_stop)   fsm_nx = FINISH;
                else if (jump) fsm_nx = READ;
                else           fsm_nx = EMIT;
            end
            EMIT: if (op_ready) fsm_nx = at_edge ? FINISH : READ;
`endif
            FINISH:  fsm_nx = IDLE;
            default: fsm_nx = IDLE;
        endcase
    end

    assign mem_rd_en = (fsm == READ);
    assign op_valid  = (fsm == EMIT);
    assign mem_row   = row_q;
    assign mem_col   = col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q    <= '0;
            col_q    <= '0;
            pre_q    <= S_M;
            case_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            end_row  <= '0;
            end_col  <= '0;
            op_code  <= OP_M;
`ifdef TB_RLE_EN
            have_run <= 1'b0;
            stopping <= 1'b0;
            run_code <= OP_M;
            run_len  <= LEN_W'(1);
            op_len_q <= LEN_W'(1);
`endif
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: if (start) begin
                    row_q    <= start_row;
                    col_q    <= start_col;
                    pre_q    <= S_M;
                    busy     <= 1'b1;
`ifdef TB_RLE_EN
                    have_run <= 1'b0;
                    stopping <= 1'b0;
`endif
                end
                WAIT: case_q <= mem_rdata;
                EVAL: begin
                    if (!is_stop) begin
                        pre_q <= s_next;
                        if (!jump) begin
                            row_q <= mv_row;
                            col_q <= mv_col;
`ifdef TB_RLE_EN
                            // A differing op flushes the old run and opens a new one
                            // with the current op still held back.
                            if (have_run && mv_op != run_code) begin
                                op_code  <= run_code;
                                op_len_q <= run_len;
                                run_code <= mv_op;
                                run_len  <= LEN_W'(1);
                            end else if (emit_now) begin
                                op_code  <= mv_op;
                                op_len_q <= new_len;
                                have_run <= 1'b0;
                            end else begin
                                run_code <= mv_op;
                                run_len  <= new_len;
                                have_run <= 1'b1;
                            end
`else
                            op_code <= mv_op;
`endif
                        end
                    end
`ifdef TB_RLE_EN
                    else begin
                        stopping <= 1'b1;
                        if (have_run) begin
                            op_code  <= run_code;
                            op_len_q <= run_len;
                            have_run <= 1'b0;
                        end
                    end
`endif
                end
`ifdef TB_RLE_EN
                EMIT: if (op_ready && (at_edge || stopping) && have_run) begin
                    op_code  <= run_code;
                    op_len_q <= run_len;
                    have_run <= 1'b0;
                end
`endif
                FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    end_row <= row_q;
                    end_col <= col_q;
                end
                default: ;
            endcase
        end
    end

endmodule
